// File: rtl/core_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory request/response channel, instruction
// delivery handshake towards the consumer, and the redirect input.
interface core_fetch_unit_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  redirect_i;
   logic [ADDR_WIDTH-1:0] redirect_addr_i;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  instr_valid_o;
   logic                  instr_ready_i;
   logic [DATA_WIDTH-1:0] instr_o;
   logic [ADDR_WIDTH-1:0] instr_pc_o;

   // Fetch unit side.
   modport master (
      input  redirect_i, redirect_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
             instr_ready_i,
      output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );

   // Environment side: program memory, consumer and branch logic.
   modport slave (
      output redirect_i, redirect_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
             instr_ready_i,
      input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o
   );
endinterface

// File: rtl/core_fetch_unit.sv
// Instruction-fetch front end: one outstanding memory request, a DEPTH-entry
// prefetch FIFO of {pc, instruction} pairs, and redirect support that flushes
// the FIFO and squashes any response still in flight.
module core_fetch_unit #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 4,
   parameter int unsigned RESET_ADDR = 0,
   parameter int unsigned ADDR_STEP  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   core_fetch_unit_if.master  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(ADDR_STEP);
   localparam logic [CNT_W-1:0]      FULL   = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,     // no request outstanding
      S_WAIT,     // granted, waiting for the response
      S_DISCARD   // granted before a redirect; response will be dropped
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count;
   entry_t                fifo [DEPTH];
   entry_t                head;
   logic                  req, grant, push, pop, valid;

   // Next-state decode plus request/push/pop strobes; redirect wins over all.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      req        = 1'b0;
      push       = 1'b0;
      case (state)
         S_IDLE: begin
            req = rst_n & (count < FULL) & ~bus.redirect_i;
            if (req && bus.mem_gnt_i) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rvalid_i) begin
               push       = ~bus.redirect_i;
               state_next = S_IDLE;
            end else if (bus.redirect_i) begin
               state_next = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (bus.mem_rvalid_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      grant = req & bus.mem_gnt_i;
      valid = (count != '0) & ~bus.redirect_i & rst_n;
      pop   = valid & bus.instr_ready_i;
   end

   assign head              = fifo[rd_ptr];
   assign bus.mem_req_o     = req;
   assign bus.mem_addr_o    = rst_n ? fetch_pc : RST_PC;
   assign bus.instr_valid_o = valid;
   assign bus.instr_o       = rst_n ? head.instr : '0;
   assign bus.instr_pc_o    = rst_n ? head.pc : '0;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Fetch address: redirect loads it, a grant records it and advances it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RST_PC;
         inflight_pc <= '0;
      end else if (bus.redirect_i) begin
         fetch_pc <= bus.redirect_addr_i;
      end else if (grant) begin
         inflight_pc <= fetch_pc;
         fetch_pc    <= fetch_pc + STEP;
      end
   end

   // FIFO pointers and occupancy; a redirect empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.redirect_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is cleared on reset so the head outputs never show stale or X data.
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      end else if (push) begin
         fifo[wr_ptr] <= '{pc: inflight_pc, instr: bus.mem_rdata_i};
      end
   end

endmodule
